// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package ifetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_FLUSH = 2'd2
  } fetch_state_t;

  // Buffered instruction as presented to decode.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] word;
  } fetch_entry_t;

  // Sequential PC advance; wraps modulo 2^32.
  function automatic logic [XLEN-1:0] pc_advance(input logic [XLEN-1:0] pc,
                                                 input logic [XLEN-1:0] step);
    return pc + step;
  endfunction

endpackage

// File: rtl/ifetch_if.sv
// Fetch-stage bus bundle: redirect input, imem request/response, decode handshake.
interface ifetch_if;
  import ifetch_pkg::*;

  logic [XLEN-1:0] new_pc;
  logic            new_pc_valid;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  logic            inst_valid;
  logic [XLEN-1:0] inst_word;
  logic [XLEN-1:0] inst_pc;
  logic [XLEN-1:0] inst_pc_plus_8;
  logic            id_ready;

  modport master (
    input  new_pc, new_pc_valid, imem_ack, imem_rvalid, imem_rdata, id_ready,
    output imem_req, imem_addr, inst_valid, inst_word, inst_pc, inst_pc_plus_8
  );

  modport slave (
    output new_pc, new_pc_valid, imem_ack, imem_rvalid, imem_rdata, id_ready,
    input  imem_req, imem_addr, inst_valid, inst_word, inst_pc, inst_pc_plus_8
  );

endinterface

// File: rtl/ifetch_fetch_fifo.sv
// Synchronous FIFO with clear, simultaneous push/pop at any occupancy. DEPTH must be a power of two.
module ifetch_fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign do_pop  = pop_i & ~empty_o;
  // A full FIFO may accept a push only when its head leaves in the same cycle.
  assign do_push = push_i & (~full_o | do_pop);

  // Pointer and occupancy update; clear dominates.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clr_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Control registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (do_push && !clr_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/ifetch.sv
// MIPS instruction fetch stage: owns the PC, issues credit-limited imem requests,
// buffers responses for decode and handles execute-stage redirects.
// Optional macro IF_STATS_EN adds saturating fetched/dropped/redirect counters.
module ifetch
  import ifetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC        = RESET_PC_DEFAULT,
  parameter int unsigned     FIFO_DEPTH      = 4,
  parameter int unsigned     MAX_OUTSTANDING = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  ifetch_if.master    bus
`ifdef IF_STATS_EN
  ,
  output logic [31:0] stat_fetched,
  output logic [31:0] stat_dropped,
  output logic [31:0] stat_redirects
`endif
);

  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned ENT_W = $bits(fetch_entry_t);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic [OUT_W-1:0] drop_q, drop_d;

  logic             redirect, resp, accept, resp_keep, pop;
  logic             imem_req_c, inst_valid_c;
  fetch_entry_t     push_entry, head;
  logic [CNT_W-1:0] inst_count, tag_count;
  logic             inst_full, inst_empty, tag_full, tag_empty;
  logic [XLEN-1:0]  tag_pc;

  assign redirect  = bus.new_pc_valid;
  assign resp      = bus.imem_rvalid;
  assign imem_req_c = (state_q != S_IDLE)
                    & (out_q < OUT_W'(MAX_OUTSTANDING))
                    & ((32'(inst_count) + 32'(out_q)) < 32'(FIFO_DEPTH))
                    & ~redirect;
  assign accept    = imem_req_c & bus.imem_ack;
  // Responses to pre-redirect requests, or arriving in a redirect cycle, are discarded.
  assign resp_keep = resp & (drop_q == '0) & ~redirect;
  assign inst_valid_c = ~inst_empty & ~redirect;
  assign pop       = inst_valid_c & bus.id_ready;

  assign push_entry.pc   = tag_pc;
  assign push_entry.word = bus.imem_rdata;

  assign bus.imem_req       = imem_req_c;
  assign bus.imem_addr      = pc_q;
  assign bus.inst_valid     = inst_valid_c;
  assign bus.inst_word      = head.word;
  assign bus.inst_pc        = head.pc;
  assign bus.inst_pc_plus_8 = pc_advance(head.pc, 32'd8);

  // PC tags of accepted requests, matched in order to surviving responses.
  ifetch_fetch_fifo #(.WIDTH(XLEN), .DEPTH(FIFO_DEPTH)) u_tag_q (
    .clk_i   (clock),
    .rst_ni  (reset_n),
    .clr_i   (redirect),
    .push_i  (accept),
    .data_i  (pc_q),
    .pop_i   (resp_keep),
    .data_o  (tag_pc),
    .count_o (tag_count),
    .full_o  (tag_full),
    .empty_o (tag_empty)
  );

  // Instruction buffer toward decode.
  ifetch_fetch_fifo #(.WIDTH(ENT_W), .DEPTH(FIFO_DEPTH)) u_inst_q (
    .clk_i   (clock),
    .rst_ni  (reset_n),
    .clr_i   (redirect),
    .push_i  (resp_keep),
    .data_i  (push_entry),
    .pop_i   (pop),
    .data_o  (head),
    .count_o (inst_count),
    .full_o  (inst_full),
    .empty_o (inst_empty)
  );

  logic unused_fifo_flags;
  assign unused_fifo_flags = ^{tag_count, tag_full, tag_empty, inst_full};

  // Next-state: PC, outstanding credit, drop counter and FSM.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    out_d   = out_q + OUT_W'(accept) - OUT_W'(resp);
    drop_d  = drop_q;
    if (accept) pc_d = pc_advance(pc_q, 32'd4);
    if (redirect) begin
      pc_d   = bus.new_pc;
      drop_d = out_d;
    end else if (resp && (drop_q != '0)) begin
      drop_d = drop_q - OUT_W'(1);
    end
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: if (redirect && (out_d != '0)) state_d = S_FLUSH;
      S_FLUSH: if (drop_d == '0) state_d = S_FETCH;
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      out_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      out_q   <= out_d;
      drop_q  <= drop_d;
    end
  end

`ifdef IF_STATS_EN
  logic [31:0] fetched_q, dropped_q, redirects_q;

  // Saturating event counters.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      fetched_q   <= '0;
      dropped_q   <= '0;
      redirects_q <= '0;
    end else begin
      if (resp_keep && (fetched_q != '1))          fetched_q   <= fetched_q + 32'd1;
      if (resp && !resp_keep && (dropped_q != '1)) dropped_q   <= dropped_q + 32'd1;
      if (redirect && (redirects_q != '1))         redirects_q <= redirects_q + 32'd1;
    end
  end

  assign stat_fetched   = fetched_q;
  assign stat_dropped   = dropped_q;
  assign stat_redirects = redirects_q;
`endif

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch with an in-order, variable-latency imem model
// and an in-order decode scoreboard.
module tb_ifetch;
  import ifetch_pkg::*;

  localparam logic [31:0] KEY = 32'hDEAD_BEEF;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  ifetch_if bus();

`ifdef IF_STATS_EN
  logic [31:0] stat_fetched, stat_dropped, stat_redirects;
  logic [31:0] d0, r0;
`endif

  ifetch dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
`ifdef IF_STATS_EN
    ,
    .stat_fetched   (stat_fetched),
    .stat_dropped   (stat_dropped),
    .stat_redirects (stat_redirects)
`endif
  );

  always #5 clock = ~clock;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  int unsigned cyc = 0;
  int unsigned mem_lat = 1;
  int unsigned n_acc = 0;
  int unsigned n_pop = 0;
  logic [31:0] pend_addr[$];
  int unsigned pend_due[$];
  logic [31:0] acc_log[$];
  logic [31:0] exp_pc;
  logic [31:0] last_pc8;
  logic        last_pop;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  // One clock: score the pop, advance the imem model, drive the next response.
  task automatic tick();
    logic acc, rv, pop;
    logic [31:0] a;
    acc = bus.imem_req & bus.imem_ack;
    a   = bus.imem_addr;
    rv  = bus.imem_rvalid;
    pop = bus.inst_valid & bus.id_ready;
    if (pop === 1'b1) begin
      check("pop_pc", bus.inst_pc, exp_pc);
      check("pop_word", bus.inst_word, exp_pc ^ KEY);
      check("pop_pc8", bus.inst_pc_plus_8, exp_pc + 32'd8);
      last_pc8 = bus.inst_pc_plus_8;
      exp_pc = exp_pc + 32'd4;
      n_pop++;
    end
    last_pop = (pop === 1'b1);
    @(posedge clock);
    #1;
    cyc++;
    if (!reset_n) begin
      pend_addr.delete();
      pend_due.delete();
    end else begin
      if (rv === 1'b1) begin
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end
      if (acc === 1'b1) begin
        pend_addr.push_back(a);
        pend_due.push_back(cyc - 1 + mem_lat);
        acc_log.push_back(a);
        n_acc++;
      end
    end
    if (reset_n && pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = pend_addr[0] ^ KEY;
    end else begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = 32'h0;
    end
    #1;
  endtask

  task automatic run_pops(input int unsigned n, input string tag);
    int unsigned target;
    int unsigned b;
    target = n_pop + n;
    b = 0;
    while (n_pop < target && b < 60) begin
      tick();
      b++;
    end
    check(tag, 32'(n_pop >= target), 32'd1);
  endtask

  task automatic wait_state(input int unsigned pend_n, input logic need_rv, input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (pend_addr.size() == pend_n && bus.imem_rvalid == need_rv &&
          (!need_rv || bus.inst_valid)) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  task automatic redirect(input logic [31:0] target);
    bus.new_pc = target;
    bus.new_pc_valid = 1'b1;
    #1;
  endtask

  initial begin
    bus.new_pc = 32'h0;
    bus.new_pc_valid = 1'b0;
    bus.imem_ack = 1'b1;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata = 32'h0;
    bus.id_ready = 1'b1;
    exp_pc = RESET_PC_DEFAULT;
    last_pc8 = 32'h0;
    last_pop = 1'b0;

    // Reset state
    reset_n = 1'b0;
    tick();
    tick();
    check("rst_req", 32'(bus.imem_req), 32'd0);
    check("rst_valid", 32'(bus.inst_valid), 32'd0);
    check("rst_addr", bus.imem_addr, 32'hBFC0_0000);
`ifdef IF_STATS_EN
    check("rst_stat_f", stat_fetched, 32'd0);
`endif
    reset_n = 1'b1;
    #1;
    check("idle_req", 32'(bus.imem_req), 32'd0);
    tick();

    // Sequential fetch and first-word latency
    check("first_req", 32'(bus.imem_req), 32'd1);
    check("addr0", bus.imem_addr, 32'hBFC0_0000);
    tick();
    check("addr1", bus.imem_addr, 32'hBFC0_0004);
    check("lat_valid0", 32'(bus.inst_valid), 32'd0);
    tick();
    check("lat_valid", 32'(bus.inst_valid), 32'd1);
    check("lat_pc", bus.inst_pc, 32'hBFC0_0000);
    check("lat_pc8", bus.inst_pc_plus_8, 32'hBFC0_0008);
    check("lat_word", bus.inst_word, 32'hBFC0_0000 ^ KEY);
    repeat (6) tick();

    // Decode stall fills the buffer exactly
    bus.id_ready = 1'b0;
    #1;
    repeat (10) tick();
    check("stall_req", 32'(bus.imem_req), 32'd0);
    check("stall_buf", 32'(n_acc - n_pop), 32'd4);
    check("stall_pend", 32'(pend_addr.size()), 32'd0);
    bus.id_ready = 1'b1;
    #1;
    tick();
    check("resume_req", 32'(bus.imem_req), 32'd1);
    run_pops(4, "stall_drain");

    // Redirect with two responses in flight
    mem_lat = 3;
    wait_state(2, 1'b0, "t3_setup");
`ifdef IF_STATS_EN
    d0 = stat_dropped;
`endif
    redirect(32'h0000_1000);
    check("t3_req", 32'(bus.imem_req), 32'd0);
    check("t3_valid", 32'(bus.inst_valid), 32'd0);
    tick();
    bus.new_pc_valid = 1'b0;
    exp_pc = 32'h0000_1000;
    #1;
    check("t3_addr", bus.imem_addr, 32'h0000_1000);
    run_pops(2, "t3_pops");
`ifdef IF_STATS_EN
    check("t3_dropped", stat_dropped - d0, 32'd2);
`endif

    // Redirect coinciding with a response while decode is ready
    mem_lat = 1;
    repeat (4) tick();
    wait_state(1, 1'b1, "t4_setup");
`ifdef IF_STATS_EN
    d0 = stat_dropped;
`endif
    redirect(32'h0000_3000);
    check("t4_valid", 32'(bus.inst_valid), 32'd0);
    tick();
    check("t4_nopop", 32'(last_pop), 32'd0);
    bus.new_pc_valid = 1'b0;
    exp_pc = 32'h0000_3000;
    #1;
    run_pops(2, "t4_pops");
`ifdef IF_STATS_EN
    check("t4_dropped", stat_dropped - d0, 32'd1);
`endif

    // Second redirect while still flushing
    mem_lat = 3;
    wait_state(2, 1'b0, "t5_setup");
`ifdef IF_STATS_EN
    d0 = stat_dropped;
    r0 = stat_redirects;
`endif
    redirect(32'h0000_5000);
    tick();
    redirect(32'h0000_2000);
    check("t5_valid", 32'(bus.inst_valid), 32'd0);
    tick();
    bus.new_pc_valid = 1'b0;
    exp_pc = 32'h0000_2000;
    #1;
    run_pops(3, "t5_pops");
`ifdef IF_STATS_EN
    check("t5_dropped", stat_dropped - d0, 32'd2);
    check("t5_redirects", stat_redirects - r0, 32'd2);
`endif

    // PC wrap at the top of the address space
    mem_lat = 1;
    repeat (4) tick();
    redirect(32'hFFFF_FFF8);
    acc_log.delete();
    tick();
    bus.new_pc_valid = 1'b0;
    exp_pc = 32'hFFFF_FFF8;
    #1;
    run_pops(2, "wrap_pops");
    check("wrap_pc8", last_pc8, 32'h0000_0004);
    run_pops(1, "wrap_pops2");
    check("wrap_n", 32'(acc_log.size() >= 3), 32'd1);
    if (acc_log.size() >= 3) begin
      check("wrap_a0", acc_log[0], 32'hFFFF_FFF8);
      check("wrap_a1", acc_log[1], 32'hFFFF_FFFC);
      check("wrap_a2", acc_log[2], 32'h0000_0000);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ifetch.md
Name: ifetch

Overview:
- Instruction fetch stage of the 5-stage MIPS pipeline; owns the architectural PC.
- Issues in-order word requests to instruction memory and buffers returned words in a small FIFO.
- Presents buffered instructions to decode with a valid/ready handshake.
- Consumes the branch/jump redirect (new_pc, new_pc_valid) that the execute stage produces: flushes the FIFO, discards in-flight responses, restarts fetch at the target.

Parameters:
- RESET_PC, 32'hBFC0_0000, PC loaded on reset.
- FIFO_DEPTH, 4, fetch buffer entries (power of two, ≥2).
- MAX_OUTSTANDING, 2, maximum issued-but-unanswered imem requests (≤FIFO_DEPTH).

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- new_pc  in  32  redirect target from execute.
- new_pc_valid  in  1  redirect strobe, one cycle per taken branch/jump.
- imem_req  out  1  request valid.
- imem_addr  out  32  word-aligned request address.
- imem_ack  in  1  request accepted this cycle (handshake = imem_req & imem_ack).
- imem_rvalid  in  1  response valid; responses in request order, ≥1 cycle after accept.
- imem_rdata  in  32  response instruction word.
- inst_valid  out  1  head entry valid toward decode.
- inst_word  out  32  head instruction.
- inst_pc  out  32  head PC.
- inst_pc_plus_8  out  32  inst_pc + 8 (link value for execute).
- id_ready  in  1  decode accepts head (pop = inst_valid & id_ready).

Behaviour:
- Reset (reset_n low at edge): pc ← RESET_PC; FIFO empty; outstanding ← 0; drop_cnt ← 0; state ← S_IDLE. Outputs: imem_req=0, inst_valid=0, imem_addr=RESET_PC. Reset mid-operation discards everything; responses arriving in the cycles right after reset are dropped only through drop_cnt=0 semantics. The imem side is reset by the same reset_n.
- FSM:
  - S_IDLE → S_FETCH unconditionally, one cycle after reset.
  - S_FETCH → S_FLUSH on new_pc_valid with outstanding (after this cycle's accept) > 0.
  - S_FLUSH → S_FETCH when drop_cnt reaches 0.
  - In S_FLUSH, another redirect reloads drop_cnt.
- Issue: imem_req = (state≠S_IDLE) & (outstanding < MAX_OUTSTANDING) & (fifo_count + outstanding < FIFO_DEPTH) & ~new_pc_valid. Each accept advances pc by 4 (mod 2^32; wraps 32'hFFFF_FFFC → 0). Each accepted request's PC is pushed into a PC tag queue.
- Credit rule guarantees a slot for every response; FIFO overflow is impossible, and the bench asserts this.
- Response: if drop_cnt>0, decrement drop_cnt and discard; otherwise push {tag_pc, imem_rdata} into the FIFO. Outstanding decrements either way.
- Redirect (new_pc_valid):
  - pc ← new_pc; FIFO and tag queue cleared.
  - drop_cnt ← outstanding after counting this cycle's accept and response.
  - A response arriving in the redirect cycle is dropped.
  - No request is issued in the redirect cycle; fetch of new_pc starts the next cycle.
  - The branch delay slot has already been consumed by decode when the branch is in execute, so no FIFO entry is preserved.
- Decode side:
  - inst_valid = ~fifo_empty & ~new_pc_valid; a pop in the redirect cycle is suppressed.
  - Push and pop in the same cycle are allowed at any occupancy, including full and empty. On empty, the pushed word appears the next cycle (1-cycle response-to-decode latency).
- Latency: redirect edge → imem_req for new_pc next cycle; zero-wait memory yields inst_valid 2 cycles after the request is accepted.

Optional Feature:
- IF_STATS_EN defined: adds outputs stat_fetched[31:0] (words pushed), stat_dropped[31:0] (responses discarded), stat_redirects[31:0]. All reset to 0, saturating, incremented once per event per cycle.
- Undefined: ports and counters absent; no other behaviour changes.

Decomposition:
- pipTypes gains fetch_state_t {S_IDLE, S_FETCH, S_FLUSH} and the RESET_PC_DEFAULT constant.
- One sub-module, fetch_fifo: parameterised width/depth synchronous FIFO with clear, push/pop, count, full/empty. Instantiated twice: instruction buffer (64-bit {pc, word}) and PC tag queue.

Test Plan:
- Reset, zero-wait imem, id_ready=1 → imem_addr BFC00000, BFC00004, …; inst_pc BFC00000 with inst_pc_plus_8 BFC00008 two cycles after the first accept.
- id_ready=0 for 10 cycles → exactly 4 words buffered, imem_req low, no overflow; release → 4 pops in order, then fetch resumes.
- 2 outstanding, new_pc_valid with new_pc=0000_1000 → both stale responses dropped (stat_dropped=2 with IF_STATS_EN), first inst_pc after redirect = 0000_1000.
- Redirect coinciding with a response and id_ready=1 → response dropped, inst_valid=0 that cycle, no pop.
- Second redirect (0000_2000) while in S_FLUSH → only 0000_2000-stream instructions reach decode.
- pc = FFFF_FFF8 via redirect → addresses FFFF_FFF8, FFFF_FFFC, 0000_0000; inst_pc_plus_8 for FFFF_FFFC = 0000_0004.
